axi_lite_sram: RTL
==================

# axi_lite_sram

AXI4-Lite memory slave that sits directly downstream of the two-master instruction/data arbiter and serves its single slave port. It holds a word-addressed on-chip memory array and has independent read and write channel state machines. Response latency is programmable, so the arbiter and both masters run against realistic, non-zero-wait-state memory.

## Interface
- BASE_ADDR, 32'h8000_0000: byte address of word 0.
- DEPTH_WORDS, 1024: number of 32-bit words; power of two.
- READ_LAT, 2: wait cycles between AR acceptance and data lookup; range 1..15.
- WRITE_LAT, 2: wait cycles between AW+W completion and commit; range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- s_araddr  in  32  read byte address.
- s_arvalid  in  1  read address valid.
- s_arsize  in  3  read size; accepted and ignored, the full aligned word is always returned.
- s_arready  out  1  read address ready.
- s_rdata  out  32  read data.
- s_rresp  out  2  read response: 2'b00 OKAY, 2'b11 DECERR.
- s_rvalid  out  1  read data valid.
- s_rready  in  1  read data ready.
- s_awaddr  in  32  write byte address.
- s_awvalid  in  1  write address valid.
- s_awready  out  1  write address ready.
- s_wdata  in  32  write data.
- s_wstrb  in  4  byte strobes; bit i enables byte lane i.
- s_wvalid  in  1  write data valid.
- s_wready  out  1  write data ready.
- s_bresp  out  2  write response, same encoding as s_rresp.
- s_bvalid  out  1  write response valid.
- s_bready  in  1  write response ready.

## Operation
- Word index = (addr - BASE_ADDR) >> 2. The address is in range when BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH_WORDS. Address bits [1:0] are ignored.
- Read FSM states: R_IDLE, R_WAIT, R_RESP.
  - R_IDLE: s_arready=1. On arvalid&arready, latch the address and load the counter with the delay minus 1, then go to R_WAIT.
  - R_WAIT: decrement the counter each cycle. When the counter is 0, register the array word (or 0 if out of range) into s_rdata, set s_rresp, and go to R_RESP.
  - R_RESP: s_rvalid=1. s_rdata and s_rresp are held stable until rvalid&rready, then go to R_IDLE.
- Write FSM states: W_IDLE, W_WAIT_W, W_WAIT_AW, W_DELAY, W_RESP.
  - W_IDLE: s_awready=1 and s_wready=1. If AW and W both handshake in the same cycle, go to W_DELAY. If only AW handshakes, go to W_WAIT_W. If only W handshakes, go to W_WAIT_AW. Latch whatever handshook.
  - W_WAIT_W: only s_wready=1. W_WAIT_AW: only s_awready=1. Completing the missing half goes to W_DELAY.
  - W_DELAY: count down as in the read path. When the counter is 0, commit the strobed byte lanes (an out-of-range write commits nothing) and go to W_RESP.
  - W_RESP: s_bvalid=1 with s_bresp held until bvalid&bready, then go to W_IDLE.
- Out-of-range accesses return DECERR. An out-of-range read returns rdata 0.
- The two FSMs are fully independent. A read lookup and a write commit to the same word in the same cycle returns the old data (read-before-write).
- Both FSMs hold exactly one outstanding transaction each. No ready signal depends combinationally on a valid.

## Timing
- Reset values (asynchronous): s_arready=1, s_awready=1, s_wready=1; s_rvalid=0, s_bvalid=0; s_rdata=0, s_rresp=0, s_bresp=0. FSMs go to R_IDLE and W_IDLE, counters to 0. Memory contents are not reset.
- Read latency: s_rvalid rises D+1 cycles after the AR handshake cycle, where D is the delay.
- Write latency: s_bvalid rises D+1 cycles after the cycle that completes AW+W. Data is visible to a read whose lookup happens in the cycle after the commit or later.
- Back-to-back: the next AR can be accepted the cycle after the R handshake. The same applies to AW/W after the B handshake.
- Reset asserted mid-transaction aborts it: no response is issued, and an uncommitted write is dropped.

## Configuration
- SRAM_RAND_DELAY_EN defined: a free-running 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'h5A on reset) advances every cycle. Each accepted read or write uses D = 1 + LFSR[2:0], giving 1..8. READ_LAT and WRITE_LAT are ignored.
- Not defined: D = READ_LAT for reads and WRITE_LAT for writes, and no LFSR is instantiated.

## Test plan
- Reset: assert rst asynchronously mid-read -> outputs take their reset values immediately; no s_rvalid follows.
- Write then read, READ_LAT=2: AW+W together to 0x8000_0010, data 0xDEADBEEF, wstrb 4'hF, then read the same address -> bvalid 3 cycles after the write handshake with bresp 00; rvalid 3 cycles after AR with rdata 0xDEADBEEF, rresp 00.
- Split write: AW to 0x8000_0020 in cycle 0, W (0x11223344, wstrb 4'b0101) in cycle 4, over prior word 0xAAAAAAAA -> read returns 0xAA22AA44.
- Out of range: read 0x7FFF_FFFC and write 0x8000_1000 -> rresp 11 with rdata 0, bresp 11; the memory is unchanged.
- Backpressure: hold s_rready=0 for 5 cycles after rvalid -> rvalid, rdata and rresp stay stable and s_arready stays 0 until the handshake.
- Concurrency: a read and a write to different words in flight simultaneously -> both complete with the correct data and responses, in any order.

Source files
------------

// File: rtl/axi_lite_sram.sv
// AXI4-Lite word-addressed SRAM slave with independent read/write FSMs and programmable latency.
// Define SRAM_RAND_DELAY_EN to replace READ_LAT/WRITE_LAT with an LFSR-driven 1..8 cycle delay.
module axi_lite_sram #(
   parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
   parameter int          DEPTH_WORDS = 1024,
   parameter int          READ_LAT    = 2,
   parameter int          WRITE_LAT   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] s_araddr,
   input  logic        s_arvalid,
   input  logic [2:0]  s_arsize,
   output logic        s_arready,
   output logic [31:0] s_rdata,
   output logic [1:0]  s_rresp,
   output logic        s_rvalid,
   input  logic        s_rready,
   input  logic [31:0] s_awaddr,
   input  logic        s_awvalid,
   output logic        s_awready,
   input  logic [31:0] s_wdata,
   input  logic [3:0]  s_wstrb,
   input  logic        s_wvalid,
   output logic        s_wready,
   output logic [1:0]  s_bresp,
   output logic        s_bvalid,
   input  logic        s_bready
);

   localparam int          AW     = $clog2(DEPTH_WORDS);
   localparam logic [32:0] SPAN   = 33'(4 * DEPTH_WORDS);
   localparam logic [1:0]  OKAY   = 2'b00;
   localparam logic [1:0]  DECERR = 2'b11;

   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
   typedef enum logic [2:0] {W_IDLE, W_WAIT_W, W_WAIT_AW, W_DELAY, W_RESP} w_state_t;

   r_state_t    r_state;
   w_state_t    w_state;
   logic [31:0] mem [DEPTH_WORDS];
   logic [31:0] r_addr, w_addr, w_data;
   logic [3:0]  w_strb, r_cnt, w_cnt;
   logic [3:0]  rd_cnt_init, wr_cnt_init;
   logic [31:0] r_off, w_off;
   logic        r_in, w_in, w_commit;
   logic        unused_bits;

   // Offsets wrap below BASE_ADDR, so one unsigned compare covers both range bounds.
   assign r_off       = r_addr - BASE_ADDR;
   assign w_off       = w_addr - BASE_ADDR;
   assign r_in        = {1'b0, r_off} < SPAN;
   assign w_in        = {1'b0, w_off} < SPAN;
   assign w_commit    = (w_state == W_DELAY) && (w_cnt == 4'd0) && w_in;
   assign unused_bits = ^{s_arsize, r_off[1:0], w_off[1:0]};

`ifdef SRAM_RAND_DELAY_EN
   logic [7:0] lfsr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) lfsr <= 8'h5A;
      else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   end

   assign rd_cnt_init = {1'b0, lfsr[2:0]};
   assign wr_cnt_init = {1'b0, lfsr[2:0]};
`else
   assign rd_cnt_init = 4'(READ_LAT - 1);
   assign wr_cnt_init = 4'(WRITE_LAT - 1);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= R_IDLE;
         r_addr    <= '0;
         r_cnt     <= '0;
         s_arready <= 1'b1;
         s_rvalid  <= 1'b0;
         s_rdata   <= '0;
         s_rresp   <= OKAY;
      end else begin
         case (r_state)
            R_IDLE: if (s_arvalid && s_arready) begin
               r_addr    <= s_araddr;
               r_cnt     <= rd_cnt_init;
               s_arready <= 1'b0;
               r_state   <= R_WAIT;
            end
            R_WAIT: if (r_cnt == 4'd0) begin
               s_rdata  <= r_in ? mem[r_off[AW+1:2]] : 32'd0;
               s_rresp  <= r_in ? OKAY : DECERR;
               s_rvalid <= 1'b1;
               r_state  <= R_RESP;
            end else begin
               r_cnt <= r_cnt - 4'd1;
            end
            R_RESP: if (s_rready) begin
               s_rvalid  <= 1'b0;
               s_arready <= 1'b1;
               r_state   <= R_IDLE;
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_state   <= W_IDLE;
         w_addr    <= '0;
         w_data    <= '0;
         w_strb    <= '0;
         w_cnt     <= '0;
         s_awready <= 1'b1;
         s_wready  <= 1'b1;
         s_bvalid  <= 1'b0;
         s_bresp   <= OKAY;
      end else begin
         case (w_state)
            W_IDLE: begin
               if (s_awvalid) w_addr <= s_awaddr;
               if (s_wvalid) begin
                  w_data <= s_wdata;
                  w_strb <= s_wstrb;
               end
               if (s_awvalid && s_wvalid) begin
                  s_awready <= 1'b0;
                  s_wready  <= 1'b0;
                  w_cnt     <= wr_cnt_init;
                  w_state   <= W_DELAY;
               end else if (s_awvalid) begin
                  s_awready <= 1'b0;
                  w_state   <= W_WAIT_W;
               end else if (s_wvalid) begin
                  s_wready <= 1'b0;
                  w_state  <= W_WAIT_AW;
               end
            end
            W_WAIT_W: if (s_wvalid) begin
               w_data   <= s_wdata;
               w_strb   <= s_wstrb;
               s_wready <= 1'b0;
               w_cnt    <= wr_cnt_init;
               w_state  <= W_DELAY;
            end
            W_WAIT_AW: if (s_awvalid) begin
               w_addr    <= s_awaddr;
               s_awready <= 1'b0;
               w_cnt     <= wr_cnt_init;
               w_state   <= W_DELAY;
            end
            W_DELAY: if (w_cnt == 4'd0) begin
               s_bresp  <= w_in ? OKAY : DECERR;
               s_bvalid <= 1'b1;
               w_state  <= W_RESP;
            end else begin
               w_cnt <= w_cnt - 4'd1;
            end
            W_RESP: if (s_bready) begin
               s_bvalid  <= 1'b0;
               s_awready <= 1'b1;
               s_wready  <= 1'b1;
               w_state   <= W_IDLE;
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   // Memory is never reset; an in-flight write is dropped because reset forces w_state out of W_DELAY.
   always_ff @(posedge clk) begin
      if (w_commit) begin
         for (int i = 0; i < 4; i++) begin
            if (w_strb[i]) mem[w_off[AW+1:2]][8*i +: 8] <= w_data[8*i +: 8];
         end
      end
   end

endmodule
